unpacker_32_8: RTL and testbench

Byte-serializing stage that consumes the 32-bit words produced by the 8-to-32 packing stage and re-emits them as a stream of 8-bit bytes on a single clock. Words are queued in a small FIFO; each word leaves as four bytes, most-significant byte first, under a valid/ready handshake on both sides. It sits directly downstream of the 8→32 converter in the bit-handling chain, after that stage's outputs have been brought into the byte clock domain.

---
 rtl/unpacker_32_8.sv | 86 ++++++++
 tb/tb_unpacker_32_8.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/unpacker_32_8.sv
// Word-to-byte serializer: buffers 32-bit words in a small FIFO and emits each
// as four bytes under valid/ready on both sides; byte order set by MSB_FIRST.
module unpacker_32_8 #(
  parameter int FIFO_DEPTH = 2,
  parameter int MSB_FIRST  = 1
) (
  input  logic                          clk,
  input  logic                          reset_L,
  input  logic                          valid_in,
  input  logic [31:0]                   data_in,
  output logic                          in_ready,
  input  logic                          out_ready,
  output logic                          valid_out,
  output logic [7:0]                    data_out,
  output logic [$clog2(FIFO_DEPTH):0]   word_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  // Handshake rule, both sides: a transfer happens at a rising edge where
  // valid and ready are both high; valid never waits on ready.
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_idx;

  logic          w_push;
  logic          w_byte_pop;
  logic          w_word_pop;
  logic [31:0]   w_head;
  logic [1:0]    w_sel;

  // in_ready looks only at stored state, so a full FIFO never accepts a word
  // even when its last byte leaves on the same edge.
  assign in_ready   = reset_L && (r_count != FULL_COUNT);
  assign valid_out  = (r_count != '0);
  assign word_count = r_count;

  assign w_push     = valid_in && in_ready;
  assign w_byte_pop = valid_out && out_ready;
  assign w_word_pop = w_byte_pop && (r_idx == 2'd3);

  assign w_head = r_mem[r_rd_ptr];
  assign w_sel  = (MSB_FIRST != 0) ? (2'd3 - r_idx) : r_idx;

  always_comb begin
    data_out = 8'h00;
    if (valid_out) begin
      data_out = w_head[{w_sel, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_idx    <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_word_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_byte_pop) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_push && !w_word_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_word_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_unpacker_32_8.sv
// Directed bench for unpacker_32_8: an MSB-first and an LSB-first instance share
// stimulus; expected bytes are queued per instance and checked by a monitor.
module tb_unpacker_32_8;

  logic        clk;
  logic        reset_L;
  logic        valid_in;
  logic [31:0] data_in;
  logic        out_ready;

  logic        in_ready_m,   in_ready_l;
  logic        valid_out_m,  valid_out_l;
  logic [7:0]  data_out_m,   data_out_l;
  logic [1:0]  word_count_m, word_count_l;

  logic [7:0] exp_q_m[$];
  logic [7:0] exp_q_l[$];

  int n_checks;
  int n_errors;

  unpacker_32_8 #(.FIFO_DEPTH(2), .MSB_FIRST(1)) u_msb (
    .clk        (clk),
    .reset_L    (reset_L),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .in_ready   (in_ready_m),
    .out_ready  (out_ready),
    .valid_out  (valid_out_m),
    .data_out   (data_out_m),
    .word_count (word_count_m)
  );

  unpacker_32_8 #(.FIFO_DEPTH(2), .MSB_FIRST(0)) u_lsb (
    .clk        (clk),
    .reset_L    (reset_L),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .in_ready   (in_ready_l),
    .out_ready  (out_ready),
    .valid_out  (valid_out_l),
    .data_out   (data_out_l),
    .word_count (word_count_l)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word pushed with its four expected bytes listed explicitly in each order.
  task automatic push(input logic [31:0] w, input logic [31:0] bytes_m,
                      input logic [31:0] bytes_l, input bit accept);
    valid_in = 1'b1;
    data_in  = w;
    if (accept) begin
      for (int i = 3; i >= 0; i--) begin
        exp_q_m.push_back(bytes_m[i*8 +: 8]);
        exp_q_l.push_back(bytes_l[i*8 +: 8]);
      end
    end
    step();
    valid_in = 1'b0;
    data_in  = 32'h0;
  endtask

  task automatic chk_both(input string name, input logic v, input logic [7:0] dm,
                          input logic [7:0] dl, input logic [1:0] wc, input logic ir);
    chk({name, " msb valid_out"},  {31'd0, valid_out_m}, {31'd0, v});
    chk({name, " msb data_out"},   {24'd0, data_out_m},  {24'd0, dm});
    chk({name, " msb word_count"}, {30'd0, word_count_m}, {30'd0, wc});
    chk({name, " msb in_ready"},   {31'd0, in_ready_m},  {31'd0, ir});
    chk({name, " lsb valid_out"},  {31'd0, valid_out_l}, {31'd0, v});
    chk({name, " lsb data_out"},   {24'd0, data_out_l},  {24'd0, dl});
    chk({name, " lsb word_count"}, {30'd0, word_count_l}, {30'd0, wc});
    chk({name, " lsb in_ready"},   {31'd0, in_ready_l},  {31'd0, ir});
  endtask

  task automatic chk_drained(input string name);
    chk({name, " msb queue left"}, exp_q_m.size(), 0);
    chk({name, " lsb queue left"}, exp_q_l.size(), 0);
  endtask

  // scoreboard monitor: inputs change just after rising edges, so a negedge
  // sample reflects exactly what the next edge will transfer
  always @(negedge clk) begin
    if (reset_L) begin
      if (valid_out_m && out_ready) begin
        if (exp_q_m.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL msb unexpected byte: got %h expected none at %0t", data_out_m, $time);
        end else begin
          chk("msb byte", {24'd0, data_out_m}, {24'd0, exp_q_m.pop_front()});
        end
      end
      if (valid_out_l && out_ready) begin
        if (exp_q_l.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL lsb unexpected byte: got %h expected none at %0t", data_out_l, $time);
        end else begin
          chk("lsb byte", {24'd0, data_out_l}, {24'd0, exp_q_l.pop_front()});
        end
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_L   = 1'b0;
    valid_in  = 1'b0;
    data_in   = 32'h0;
    out_ready = 1'b0;

    #2;
    chk_both("reset", 1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
    step();
    step();
    reset_L = 1'b1;
    #1;
    chk_both("after release", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);

    // single word
    out_ready = 1'b1;
    push(32'hFFDDEE11, 32'hFFDDEE11, 32'h11EEDDFF, 1'b1);
    chk_both("single first byte", 1'b1, 8'hFF, 8'h11, 2'd1, 1'b1);
    repeat (4) step();
    chk_both("single drained", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    chk_drained("single");

    // back-pressure fill, third push refused
    out_ready = 1'b0;
    push(32'h01020304, 32'h01020304, 32'h04030201, 1'b1);
    push(32'hA0B0C0D0, 32'hA0B0C0D0, 32'hD0C0B0A0, 1'b1);
    chk_both("full", 1'b1, 8'h01, 8'h04, 2'd2, 1'b0);
    push(32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
    chk_both("full after refused push", 1'b1, 8'h01, 8'h04, 2'd2, 1'b0);
    out_ready = 1'b1;
    repeat (8) step();
    chk_both("fill drained", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    chk_drained("fill");

    // stall mid-word after byte 2 of the word is accepted
    push(32'h01020304, 32'h01020304, 32'h04030201, 1'b1);
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_both("stall hold", 1'b1, 8'h03, 8'h02, 2'd1, 1'b1);
      step();
    end
    out_ready = 1'b1;
    step();
    step();
    chk_both("stall drained", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    chk_drained("stall");

    // push on the same edge the last byte pops
    push(32'h11223344, 32'h11223344, 32'h44332211, 1'b1);
    step();
    step();
    step();
    push(32'h55667788, 32'h55667788, 32'h88776655, 1'b1);
    chk_both("push with pop", 1'b1, 8'h55, 8'h88, 2'd1, 1'b1);
    repeat (4) step();
    chk_both("push with pop drained", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    chk_drained("push with pop");

    // asynchronous reset mid-word
    push(32'hFFDDEE11, 32'hFFDDEE11, 32'h11EEDDFF, 1'b1);
    step();
    step();
    #2;
    reset_L = 1'b0;
    exp_q_m.delete();
    exp_q_l.delete();
    #1;
    chk_both("mid-word reset", 1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
    step();
    reset_L = 1'b1;
    #1;
    push(32'h00000003, 32'h00000003, 32'h03000000, 1'b1);
    chk_both("post-reset first byte", 1'b1, 8'h00, 8'h03, 2'd1, 1'b1);
    repeat (4) step();
    chk_both("post-reset drained", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    chk_drained("post-reset");

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
